// File: rtl/ring_meas_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ring_meas_pkg
// Description : Shared types and helpers for the ring-oscillator frequency
//               counter: measurement FSM states and gate-counter sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package ring_meas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_DONE    = 2'd2
    } meas_state_e;

    // Width needed to count 0..cycles-1; never narrower than one bit.
    function automatic int gate_cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : ring_meas_pkg
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge_det
// Description : Multi-flop synchronizer for an asynchronous input followed by
//               a rising-edge detector (one-cycle pulse per synchronized rise).
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic edge_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign edge_out = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule : sync_edge_det
`default_nettype wire

// File: rtl/ring_freq_counter.sv
`default_nettype none
// ============================================================================
// Module      : ring_freq_counter
// Description : Counts synchronized rising edges of a ring-oscillator output
//               over a fixed window of GATE_CYCLES clk cycles, single-shot or
//               back-to-back, with saturation flag and one-cycle result strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module ring_freq_counter
    import ring_meas_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int GATE_CYCLES = 1000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             osc_in,
    input  logic             start,
    input  logic             continuous,
    output logic             busy,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
    output logic             overflow
);

    localparam int                C_GATE_W    = gate_cnt_width(GATE_CYCLES);
    localparam logic [C_GATE_W-1:0] C_GATE_LAST = C_GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  C_CNT_MAX   = '1;

    meas_state_e          state_q, state_d;
    logic [CNT_W-1:0]     edge_cnt_q, edge_cnt_d;
    logic [C_GATE_W-1:0]  gate_cnt_q, gate_cnt_d;
    logic                 sat_q, sat_d;
    logic [CNT_W-1:0]     count_out_q, count_out_d;
    logic                 overflow_q, overflow_d;
    logic                 w_osc_edge;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_det (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (osc_in),
        .edge_out (w_osc_edge)
    );

    always_comb begin
        state_d     = state_q;
        edge_cnt_d  = edge_cnt_q;
        gate_cnt_d  = gate_cnt_q;
        sat_d       = sat_q;
        count_out_d = count_out_q;
        overflow_d  = overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (start || continuous) begin
                    state_d    = ST_MEASURE;
                    edge_cnt_d = '0;
                    gate_cnt_d = '0;
                    sat_d      = 1'b0;
                end
            end

            ST_MEASURE: begin
                gate_cnt_d = gate_cnt_q + 1'b1;
                if (w_osc_edge) begin
                    if (edge_cnt_q == C_CNT_MAX) begin
                        sat_d = 1'b1;
                    end else begin
                        edge_cnt_d = edge_cnt_q + 1'b1;
                    end
                end
                // Result is latched here so it is already visible while
                // count_valid is high in DONE, including a final-cycle edge.
                if (gate_cnt_q == C_GATE_LAST) begin
                    state_d     = ST_DONE;
                    gate_cnt_d  = '0;
                    count_out_d = edge_cnt_d;
                    overflow_d  = sat_d;
                end
            end

            ST_DONE: begin
                if (continuous) begin
                    state_d    = ST_MEASURE;
                    edge_cnt_d = '0;
                    gate_cnt_d = '0;
                    sat_d      = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            edge_cnt_q  <= '0;
            gate_cnt_q  <= '0;
            sat_q       <= 1'b0;
            count_out_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            edge_cnt_q  <= edge_cnt_d;
            gate_cnt_q  <= gate_cnt_d;
            sat_q       <= sat_d;
            count_out_q <= count_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign count_valid = (state_q == ST_DONE);
    assign count_out   = count_out_q;
    assign overflow    = overflow_q;

endmodule : ring_freq_counter
`default_nettype wire
